conv_tile_sequencer: RTL and testbench
======================================

Name: conv_tile_sequencer

Overview:
- Control and buffering stage wrapped around the 3x3-filter / 4x4-input systolic convolution array.
- Upstream side: accepts a byte stream (16 input pixels, then 9 filter taps), assembles the tile and filter registers, and drives them in parallel to the array.
- Sequencing: holds the array in reset while loading, releases it, and counts the compute window.
- Downstream side: captures the four 2x2 results and streams them out over a valid/ready interface. It then returns to loading for the next tile.

Parameters:
- DATA_W, 8, width of pixels, taps and results.
- COMPUTE_CYCLES, 14, clk cycles from array-reset release to result capture (range 1..31).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  upstream byte valid.
- s_ready  out  1  upstream byte accept.
- s_data  in  DATA_W  upstream byte.
- tile_out  out  16*DATA_W  input pixels to the array; byte k at bits [k*DATA_W +: DATA_W]; k=0 is input11, k=15 is input44, row-major.
- filt_out  out  9*DATA_W  filter taps to the array; k=0 is filter11, k=8 is filter33, row-major.
- arr_rst  out  1  reset driven to the array, active-high.
- res_in  in  4*DATA_W  array results: [0] result11, [1] result12, [2] result21, [3] result22.
- m_valid  out  1  downstream result valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  downstream result byte.
- busy  out  1  high whenever the state is not LOAD.
- tile_done  out  1  one-cycle pulse when the 4th result is accepted.

Behaviour:
- Reset values: state LOAD, byte index 0, tile_out 0, filt_out 0, captured results 0, arr_rst 1, s_ready 1, m_valid 0, m_data 0, busy 0, tile_done 0, compute counter 0.
- State LOAD:
  - s_ready=1, arr_rst=1.
  - A byte transfers when s_valid&s_ready.
  - Index 0..15 writes tile byte[idx]; index 16..24 writes filter byte[idx-16].
  - Index increments per transfer. The transfer at index 24 wraps the index to 0 and moves to ARM.
- State ARM:
  - Lasts exactly one cycle; s_ready=0, arr_rst=1.
  - Then moves to COMPUTE with counter=0.
- State COMPUTE:
  - arr_rst=0, s_ready=0; counter increments each cycle.
  - In the cycle where counter==COMPUTE_CYCLES-1, res_in is registered into the result regs, and the state moves to DRAIN with out index 0.
- State DRAIN:
  - arr_rst=1, which returns the array to idle; s_ready=0.
  - m_valid=1 and m_data=result[out index], both driven from registers.
  - Each m_valid&m_ready advances the out index. When the index-3 transfer completes: tile_done pulses, m_valid drops the next cycle, and the state returns to LOAD.
- Backpressure: while m_ready=0, m_valid and m_data hold stable. Setting m_ready=1 constantly drains all four results in 4 consecutive cycles.
- tile_out and filt_out change only in LOAD. They are stable through ARM, COMPUTE and DRAIN.
- s_valid outside LOAD is ignored and no byte is consumed.
- Reset mid-operation, in any state: all registers return to their reset values immediately. A partially loaded tile is discarded, and arr_rst asserts asynchronously.
- Minimum latency from the last input byte accepted to first m_valid = 1 (ARM) + COMPUTE_CYCLES cycles.
- busy = (state != LOAD).

Test Plan:
- Load bytes 1..25 with s_valid held high, then stub res_in={8'h04,8'h03,8'h02,8'h01} and m_ready=1 -> tile_out byte0=1, byte15=16; filt_out byte0=17, byte8=25; arr_rst low for exactly 14 cycles; m_data sequence 01,02,03,04 on consecutive cycles; one tile_done pulse.
- Insert s_valid gaps (toggle every other cycle) during load -> the same tile and filter contents as the gap-free case; ARM entered only after the 25th accepted byte.
- Hold m_ready=0 for 5 cycles in DRAIN, then 1 -> m_data stays 01 with m_valid high throughout the stall; then 02,03,04 follow; s_ready stays 0 until after the 4th transfer.
- Change res_in after capture (to 8'hFF per lane) -> streamed values remain 01..04; a second tile load then produces new captured values.
- Assert rst for 1 cycle after 10 bytes loaded -> arr_rst=1, index 0, tile_out=0; a following full 25-byte load produces the correct tile.
- Drive s_valid=1 with s_data=8'hAA during COMPUTE -> s_ready=0 and tile/filter registers unchanged.

Source files
------------

// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer
//   Control and buffering stage around the 3x3-filter / 4x4-input systolic
//   convolution array.
//   LOAD    : takes 16 pixel bytes and then 9 filter bytes from the upstream stream.
//   ARM     : holds the array in reset for one more cycle.
//   COMPUTE : releases the array for COMPUTE_CYCLES cycles, then captures the
//             four results.
//   DRAIN   : streams the four results downstream, then returns to LOAD.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   s_valid/s_ready   upstream byte handshake; s_data is the byte
//   tile_out          16 pixels to the array, byte k = input(row,col), row-major
//   filt_out          9 taps to the array, byte k = filter(row,col), row-major
//   arr_rst           active-high reset to the array
//   res_in            array results {result22, result21, result12, result11}
//   m_valid/m_ready   downstream result handshake; m_data is the result byte
//   busy              high whenever the sequencer is not in LOAD
//   tile_done         one-cycle pulse after the 4th result is accepted
module conv_tile_sequencer #(
  parameter int DATA_W         = 8,
  parameter int COMPUTE_CYCLES = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  output logic [16*DATA_W-1:0] tile_out,
  output logic [9*DATA_W-1:0]  filt_out,
  output logic                 arr_rst,
  input  logic [4*DATA_W-1:0]  res_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic                 busy,
  output logic                 tile_done
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_ARM     = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(COMPUTE_CYCLES - 1);

  state_t                state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [1:0]            out_idx_q, out_idx_d;
  logic [16*DATA_W-1:0]  tile_q, tile_d;
  logic [9*DATA_W-1:0]   filt_q, filt_d;
  logic [4*DATA_W-1:0]   res_q, res_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic                  tile_done_q, tile_done_d;

  // State and datapath registers; rst clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      idx_q       <= 5'd0;
      cnt_q       <= 5'd0;
      out_idx_q   <= 2'd0;
      tile_q      <= '0;
      filt_q      <= '0;
      res_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_idx_q   <= out_idx_d;
      tile_q      <= tile_d;
      filt_q      <= filt_d;
      res_q       <= res_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_idx_d   = out_idx_q;
    tile_d      = tile_q;
    filt_d      = filt_q;
    res_d       = res_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    tile_done_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          if (idx_q < 5'd16) begin
            tile_d[idx_q*DATA_W +: DATA_W] = s_data;
          end else begin
            filt_d[(idx_q - 5'd16)*DATA_W +: DATA_W] = s_data;
          end
          if (idx_q == 5'd24) begin
            idx_d   = 5'd0;
            state_d = ST_ARM;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_ARM: begin
        cnt_d   = 5'd0;
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          // Capture the results and present the first one from a register.
          res_d     = res_in;
          m_data_d  = res_in[DATA_W-1:0];
          m_valid_d = 1'b1;
          out_idx_d = 2'd0;
          cnt_d     = 5'd0;
          state_d   = ST_DRAIN;
        end else begin
          state_d = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        if (m_valid_q && m_ready) begin
          if (out_idx_q == 2'd3) begin
            m_valid_d   = 1'b0;
            tile_done_d = 1'b1;
            out_idx_d   = 2'd0;
            state_d     = ST_LOAD;
          end else begin
            out_idx_d = out_idx_q + 2'd1;
            m_data_d  = res_q[(out_idx_q + 2'd1)*DATA_W +: DATA_W];
          end
        end else begin
          m_valid_d = m_valid_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Status outputs decode straight from the state register, so arr_rst
  // follows rst asynchronously.
  assign s_ready   = (state_q == ST_LOAD);
  assign arr_rst   = (state_q != ST_COMPUTE);
  assign busy      = (state_q != ST_LOAD);
  assign tile_out  = tile_q;
  assign filt_out  = filt_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign tile_done = tile_done_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
module tb_conv_tile_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic [127:0] tile_out;
  logic [71:0]  filt_out;
  logic         arr_rst;
  logic [31:0]  res_in;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   m_data;
  logic         busy;
  logic         tile_done;

  conv_tile_sequencer #(.DATA_W(8), .COMPUTE_CYCLES(14)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tile_out(tile_out), .filt_out(filt_out), .arr_rst(arr_rst),
    .res_in(res_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int low_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected byte for every accepted result.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (!arr_rst) low_cnt++;
      if (tile_done) done_cnt++;
      if (m_valid) valid_cnt++;
      if (prev_stall) chk("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got %0h expected none", m_data);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  function automatic logic [127:0] exp_tile(input int base);
    logic [127:0] t;
    t = '0;
    for (int k = 0; k < 16; k++) t[k*8 +: 8] = 8'(base + k);
    return t;
  endfunction

  function automatic logic [71:0] exp_filt(input int base);
    logic [71:0] f;
    f = '0;
    for (int k = 0; k < 9; k++) f[k*8 +: 8] = 8'(base + 16 + k);
    return f;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_tile(input int base, input bit gaps);
    for (int i = 0; i < 25; i++) begin
      if (gaps && i == 24) chk("no_arm_before_last", {127'd0, busy}, 128'd0);
      s_valid = 1'b1;
      s_data  = 8'(base + i);
      step(1);
      if (gaps && i == 24) chk("arm_after_last", {127'd0, busy}, 128'd1);
      if (gaps) begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        step(1);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int done_before, input string nm);
    int t;
    t = 0;
    while (done_cnt == done_before && t < 200) begin
      step(1);
      t++;
    end
    if (done_cnt == done_before) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no tile_done expected pulse", nm);
    end
    step(2);
  endtask

  task automatic push_res(input logic [31:0] r);
    for (int k = 0; k < 4; k++) exp_q.push_back(r[k*8 +: 8]);
  endtask

  int lat;
  int d0, l0, v0;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    res_in = {8'h04, 8'h03, 8'h02, 8'h01};
    step(3);
    chk("rst_outputs", {122'd0, arr_rst, s_ready, m_valid, busy, tile_done, 1'b0},
        {122'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_tile", tile_out, 128'd0);
    chk("rst_filt", {56'd0, filt_out}, 128'd0);
    chk("rst_mdata", {120'd0, m_data}, 128'd0);
    rst = 1'b0;
    step(1);

    // Tile 1: gap-free load, full-rate drain.
    d0 = done_cnt; l0 = low_cnt; v0 = valid_cnt;
    load_tile(1, 1'b0);
    chk("t1_tile", tile_out, exp_tile(1));
    chk("t1_filt", {56'd0, filt_out}, {56'd0, exp_filt(1)});
    chk("t1_arm", {126'd0, busy, s_ready}, {126'd0, 1'b1, 1'b0});
    push_res(res_in);
    lat = 0;
    while (!m_valid && lat < 100) begin
      step(1);
      lat++;
    end
    chk("t1_latency", 128'(lat), 128'd15);
    wait_done(d0, "t1");
    chk("t1_arr_rst_low", 128'(low_cnt - l0), 128'd14);
    chk("t1_done_pulses", 128'(done_cnt - d0), 128'd1);
    chk("t1_valid_cycles", 128'(valid_cnt - v0), 128'd4);
    chk("t1_back_to_load", {126'd0, s_ready, busy}, {126'd0, 1'b1, 1'b0});

    // Tile 2: gapped load, stalled drain, res_in changed after capture.
    d0 = done_cnt; v0 = valid_cnt;
    m_ready = 1'b0;
    load_tile(1, 1'b1);
    chk("t2_tile", tile_out, exp_tile(1));
    chk("t2_filt", {56'd0, filt_out}, {56'd0, exp_filt(1)});
    push_res(res_in);
    lat = 0;
    while (!m_valid && lat < 100) begin
      step(1);
      lat++;
    end
    res_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall", {118'd0, m_valid, s_ready, m_data}, {118'd0, 1'b1, 1'b0, 8'h01});
      step(1);
    end
    m_ready = 1'b1;
    wait_done(d0, "t2");
    chk("t2_valid_cycles", 128'(valid_cnt - v0), 128'd9);

    // Tile 3: new results, s_valid ignored during COMPUTE.
    d0 = done_cnt;
    res_in = {8'h40, 8'h30, 8'h20, 8'h10};
    load_tile(101, 1'b0);
    step(2);
    s_valid = 1'b1; s_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      chk("t3_compute_ignore", {126'd0, s_ready, arr_rst}, 128'd0);
      step(1);
    end
    s_valid = 1'b0;
    chk("t3_tile_hold", tile_out, exp_tile(101));
    chk("t3_filt_hold", {56'd0, filt_out}, {56'd0, exp_filt(101)});
    push_res(res_in);
    wait_done(d0, "t3");

    // Reset after 10 bytes discards the partial tile.
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 8'(200 + i);
      step(1);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_state", {125'd0, arr_rst, busy, s_ready}, {125'd0, 1'b1, 1'b0, 1'b1});
    chk("mid_rst_tile", tile_out, 128'd0);
    step(1);
    rst = 1'b0;
    d0 = done_cnt;
    res_in = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
    load_tile(51, 1'b0);
    chk("t4_tile", tile_out, exp_tile(51));
    chk("t4_filt", {56'd0, filt_out}, {56'd0, exp_filt(51)});
    push_res(res_in);
    wait_done(d0, "t4");

    // Reset during COMPUTE raises arr_rst immediately.
    load_tile(61, 1'b0);
    step(4);
    chk("comp_arr_rst_low", {127'd0, arr_rst}, 128'd0);
    rst = 1'b1;
    #1;
    chk("comp_rst_async", {126'd0, arr_rst, busy}, {126'd0, 1'b1, 1'b0});
    step(1);
    rst = 1'b0;
    step(20);
    chk("no_leftover", {127'd0, m_valid}, 128'd0);
    chk("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
